pl_dmem_wait: RTL and testbench

Wait-state data-memory responder that serves the pipeline's MEM stage. It accepts one load or store request at a time and completes it after a configurable number of wait cycles. While the access is pending it drives a stall back to the pipeline. Stores are byte-lane masked, and out-of-range or misaligned accesses are flagged instead of silently wrapping.

---
 rtl/pl_mem_pkg.sv | 25 ++
 rtl/pl_dmem_array.sv | 41 ++++
 rtl/pl_dmem_wait.sv | 112 +++++++++++
 tb/tb_pl_dmem_wait.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pl_mem_pkg.sv
// Shared types and helpers for the wait-state data memory.
// State encoding, wait counter type and address legality check.
package pl_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [3:0] cnt_t;

    localparam int WORD_BYTES = 4;

    // Word aligned and inside the array; wider compare avoids wrap.
    function automatic logic addr_legal(
        input logic [31:0] a,
        input int unsigned depth_words
    );
        logic [33:0] w_lim;
        w_lim = 34'(depth_words) * 34'(WORD_BYTES);
        return (a[1:0] == 2'b00) && ({2'b00, a} < w_lim);
    endfunction

endpackage

// File: rtl/pl_dmem_array.sv
// Single-port synchronous RAM, 32-bit words, byte write mask.
// Read port is registered and holds unless a read is enabled.
module pl_dmem_array
    import pl_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_en,
    input  logic                           i_we,
    input  logic [3:0]                     i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pl_dmem_wait.sv
// Wait-state data-memory responder for the MEM stage.
// One access in flight; stalls the pipeline until completion.
module pl_dmem_wait
    import pl_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT        = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam cnt_t WAIT_CNT = cnt_t'(WAIT);

    state_t        r_state;
    state_t        w_next;
    cnt_t          r_cnt;
    cnt_t          w_cnt;
    logic          r_we;
    logic          r_legal;
    logic          r_zero;
    logic [3:0]    r_be;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   w_rdata;
    logic          w_done;
    logic          w_mem_en;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_legal <= 1'b0;
            r_be    <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (r_state == IDLE && req) begin
                r_we    <= we;
                r_be    <= be;
                r_idx   <= addr[AW+1:2];
                r_wdata <= datain;
                r_legal <= addr_legal(addr, DEPTH_WORDS);
            end
            // Illegal loads read back as zero without touching the RAM.
            if (w_done && !r_we) begin
                r_zero <= ~r_legal;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_cnt  = WAIT_CNT;
                    w_next = (WAIT_CNT == '0) ? DONE : WAITING;
                end
            end
            WAITING: begin
                w_cnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_done   = (r_state == DONE);
    assign w_mem_en = w_done & r_legal;

    pl_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .rst_n  (clrn),
        .i_en   (w_mem_en),
        .i_we   (r_we),
        .i_be   (r_be),
        .i_idx  (r_idx),
        .i_wdata(r_wdata),
        .o_rdata(w_rdata)
    );

    assign dataout = r_zero ? 32'h0 : w_rdata;
    assign ready   = w_done;
    assign err     = w_done & ~r_legal;
    assign stall   = req & ~ready;

endmodule

// File: tb/tb_pl_dmem_wait.sv
// Directed bench: u0 runs WAIT=2/1024 words, u1 runs WAIT=0/16 words.
// Inputs driven and outputs sampled in the low clock phase.
module tb_pl_dmem_wait;

    logic        clk;
    logic        clrn;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  be      [2];
    logic [31:0] addr    [2];
    logic [31:0] datain  [2];
    logic [31:0] dataout [2];
    logic [1:0]  ready;
    logic [1:0]  stall;
    logic [1:0]  err;

    int n_checks;
    int n_errors;

    pl_dmem_wait #(.DEPTH_WORDS(1024), .WAIT(2)) u0 (
        .clk(clk), .clrn(clrn), .req(req[0]), .we(we[0]),
        .be(be[0]), .addr(addr[0]), .datain(datain[0]),
        .dataout(dataout[0]), .ready(ready[0]),
        .stall(stall[0]), .err(err[0])
    );

    pl_dmem_wait #(.DEPTH_WORDS(16), .WAIT(0)) u1 (
        .clk(clk), .clrn(clrn), .req(req[1]), .we(we[1]),
        .be(be[1]), .addr(addr[1]), .datain(datain[1]),
        .dataout(dataout[1]), .ready(ready[1]),
        .stall(stall[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on DUT d; optionally swaps addr/data after capture.
    task automatic acc(
        input  int          d,
        input  logic        w,
        input  logic [3:0]  b,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  bit          swap,
        input  logic [31:0] a2,
        input  logic [31:0] wd2,
        output int          ns,
        output int          nr,
        output int          ne,
        output logic [31:0] rd,
        output logic        ra
    );
        ns = 0;
        nr = 0;
        ne = 0;
        @(negedge clk);
        req[d]    = 1'b1;
        we[d]     = w;
        be[d]     = b;
        addr[d]   = a;
        datain[d] = wd;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall[d]) ns++;
            if (ready[d]) begin
                nr++;
                if (err[d]) ne++;
                break;
            end
            @(negedge clk);
            if (swap && i == 0) begin
                addr[d]   = a2;
                datain[d] = wd2;
            end
        end
        req[d] = 1'b0;
        @(posedge clk);
        #1;
        rd = dataout[d];
        ra = ready[d];
    endtask

    int          ns, nr, ne;
    logic [31:0] rd;
    logic        ra;
    logic        seen;
    logic [7:0]  pat;

    initial begin
        n_checks = 0;
        n_errors = 0;
        req  = '0;
        we   = '0;
        for (int k = 0; k < 2; k++) begin
            be[k] = '0;
            addr[k] = '0;
            datain[k] = '0;
        end
        clrn = 1'b0;
        req[0] = 1'b1;
        #2;
        chk("rst_dataout", dataout[0], 32'h0);
        chk("rst_ready", {31'b0, ready[0]}, 32'h0);
        chk("rst_err", {31'b0, err[0]}, 32'h0);
        chk("rst_stall_follows_req", {31'b0, stall[0]}, 32'h1);
        req[0] = 1'b0;
        #1;
        chk("rst_stall_low", {31'b0, stall[0]}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;

        // Full-word store then load, WAIT=2.
        acc(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("st_stall_cycles", 32'(ns), 32'd3);
        chk("st_ready", 32'(nr), 32'd1);
        chk("st_err", 32'(ne), 32'd0);
        chk("st_ready_pulse", {31'b0, ra}, 32'h0);
        acc(0, 0, 4'h0, 32'h10, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("ld_stall_cycles", 32'(ns), 32'd3);
        chk("ld_data", rd, 32'hDEADBEEF);

        // Byte-lane store leaves other lanes and dataout alone.
        acc(0, 1, 4'b0001, 32'h10, 32'h000000AA, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("bst_dataout_hold", rd, 32'hDEADBEEF);
        acc(0, 0, 4'h0, 32'h10, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("bst_ld", rd, 32'hDEADBEAA);

        // Empty byte mask: completes, no error, no write.
        acc(0, 1, 4'b0000, 32'h10, 32'h11111111, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("be0_ready", 32'(nr), 32'd1);
        chk("be0_err", 32'(ne), 32'd0);
        acc(0, 0, 4'h0, 32'h10, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("be0_ld", rd, 32'hDEADBEAA);

        // Misaligned load.
        acc(0, 0, 4'h0, 32'h13, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("mis_ready", 32'(nr), 32'd1);
        chk("mis_err", 32'(ne), 32'd1);
        chk("mis_data", rd, 32'h0);

        // Out-of-range store must not alias onto word 0.
        acc(0, 1, 4'hF, 32'h0, 32'h11223344, 0, 0, 0, ns, nr, ne, rd, ra);
        acc(0, 1, 4'hF, 32'd4096, 32'hFFFFFFFF, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("oor_err", 32'(ne), 32'd1);
        acc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("oor_word0", rd, 32'h11223344);
        chk("oor_ld_err", 32'(ne), 32'd0);

        // Reset during WAITING aborts a store.
        acc(0, 1, 4'hF, 32'h20, 32'h12345678, 0, 0, 0, ns, nr, ne, rd, ra);
        @(negedge clk);
        req[0]    = 1'b1;
        we[0]     = 1'b1;
        be[0]     = 4'hF;
        addr[0]   = 32'h20;
        datain[0] = 32'hCAFEF00D;
        @(negedge clk);
        clrn   = 1'b0;
        req[0] = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            seen = seen | ready[0];
            @(negedge clk);
        end
        chk("abort_no_ready", {31'b0, seen}, 32'h0);
        chk("abort_dataout", dataout[0], 32'h0);
        clrn = 1'b1;
        acc(0, 0, 4'h0, 32'h20, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("abort_old_word", rd, 32'h12345678);

        // Fields changed while waiting are ignored.
        acc(0, 1, 4'hF, 32'h40, 32'h0BADF00D, 0, 0, 0, ns, nr, ne, rd, ra);
        acc(0, 1, 4'hF, 32'h10, 32'h77777777, 1, 32'h40, 32'h99999999,
            ns, nr, ne, rd, ra);
        chk("swap_stall", 32'(ns), 32'd3);
        acc(0, 0, 4'h0, 32'h10, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("swap_ld10", rd, 32'h77777777);
        acc(0, 0, 4'h0, 32'h40, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("swap_ld40", rd, 32'h0BADF00D);

        // WAIT=0 instance.
        acc(1, 1, 4'hF, 32'h0, 32'hA5A55A5A, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("w0_st_stall", 32'(ns), 32'd1);
        acc(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("w0_ld_stall", 32'(ns), 32'd1);
        chk("w0_ld_data", rd, 32'hA5A55A5A);
        acc(1, 0, 4'h0, 32'h40, 32'h0, 0, 0, 0, ns, nr, ne, rd, ra);
        chk("w0_oor_err", 32'(ne), 32'd1);
        chk("w0_oor_data", rd, 32'h0);

        // Held req: one completion every second cycle.
        @(negedge clk);
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 32'h0;
        pat     = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            pat[i] = ready[1];
            @(negedge clk);
        end
        req[1] = 1'b0;
        chk("w0_b2b_pattern", {24'b0, pat}, 32'h000000AA);
        #1;
        chk("w0_b2b_data", dataout[1], 32'hA5A55A5A);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
